// File: rtl/mc_match_if.sv
// Bus between the reaction-game master controller and its surroundings:
// button/tick/random inputs in, display and score outputs back.
interface mc_match_if #(
  parameter int N_PLAYERS = 2,
  parameter int ID_W      = 1,
  parameter int WIN_W     = 4
);
  logic                       slowen_i;
  logic                       rand_i;
  logic [N_PLAYERS-1:0]       press_i;
  logic                       restart_i;
  logic                       leds_on_o;
  logic                       clear_o;
  logic [1:0]                 led_control_o;
  logic                       round_win_o;
  logic                       foul_o;
  logic [ID_W-1:0]            winner_id_o;
  logic [N_PLAYERS*WIN_W-1:0] scores_o;
  logic                       match_over_o;

  modport slave (
    input  slowen_i, rand_i, press_i, restart_i,
    output leds_on_o, clear_o, led_control_o, round_win_o, foul_o,
           winner_id_o, scores_o, match_over_o
  );

  modport master (
    output slowen_i, rand_i, press_i, restart_i,
    input  leds_on_o, clear_o, led_control_o, round_win_o, foul_o,
           winner_id_o, scores_o, match_over_o
  );
endinterface

// File: rtl/mc_match.sv
// Master controller for the N-player reaction game: round sequencing,
// winner arbitration, foul detection, score keeping and match end.
module mc_match #(
  parameter int N_PLAYERS      = 2,
  parameter int ID_W           = 1,
  parameter int WIN_W          = 4,
  parameter int MATCH_WINS     = 3,
  parameter int WAIT_TICKS     = 2,
  parameter int GLOAT_TICKS    = 2,
  parameter int MIN_DARK_TICKS = 1
) (
  input logic        clk,
  input logic        rst_n,
  mc_match_if.slave  bus
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT      = 3'd1;
  localparam logic [2:0] S_DARK      = 3'd2;
  localparam logic [2:0] S_PLAY      = 3'd3;
  localparam logic [2:0] S_GLOAT     = 3'd4;
  localparam logic [2:0] S_FOUL      = 3'd5;
  localparam logic [2:0] S_MATCH_END = 3'd6;

  localparam int MAX_T = (WAIT_TICKS > GLOAT_TICKS)
                         ? ((WAIT_TICKS > MIN_DARK_TICKS) ? WAIT_TICKS : MIN_DARK_TICKS)
                         : ((GLOAT_TICKS > MIN_DARK_TICKS) ? GLOAT_TICKS : MIN_DARK_TICKS);
  localparam int CNT_W = $clog2(MAX_T + 2);

  localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(WAIT_TICKS);
  localparam logic [CNT_W-1:0] GLOAT_C = CNT_W'(GLOAT_TICKS);
  localparam logic [CNT_W-1:0] DARK_C  = CNT_W'(MIN_DARK_TICKS);

  logic [2:0]                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [N_PLAYERS*WIN_W-1:0] scores_q, scores_d;
  logic [ID_W-1:0]            winner_q, winner_d, low_id;
  logic                       any_press;
  logic [WIN_W-1:0]           old_score, new_score;
  logic                       round_win_q, round_win_d;
  logic                       leds_on_q, leds_on_d;
  logic                       clear_q, clear_d;
  logic [1:0]                 ctrl_q, ctrl_d;
  logic                       foul_q, match_over_q;

  // Fixed-priority arbitration: the lowest pressed index wins.
  always_comb begin
    low_id    = '0;
    any_press = 1'b0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (bus.press_i[i] && !any_press) begin
        low_id    = ID_W'(i);
        any_press = 1'b1;
      end
    end
  end

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign old_score = scores_q[low_id*WIN_W +: WIN_W];
  assign new_score = (old_score == '1) ? old_score : old_score + WIN_W'(1);

  // Next-state, score, winner and tick-counter logic.
  always_comb begin
    state_d     = state_q;
    scores_d    = scores_q;
    winner_d    = winner_q;
    round_win_d = 1'b0;
    case (state_q)
      S_RESET: state_d = S_WAIT;
      S_WAIT:  if (bus.slowen_i && cnt_inc == WAIT_C) state_d = S_DARK;
      S_DARK: begin
        if (any_press) begin
          state_d  = S_FOUL;
          winner_d = low_id;
        end else if (cnt_q >= DARK_C && bus.slowen_i && bus.rand_i) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (any_press) begin
          scores_d[low_id*WIN_W +: WIN_W] = new_score;
          winner_d    = low_id;
          round_win_d = 1'b1;
          if (MATCH_WINS != 0 && 32'(new_score) == 32'(MATCH_WINS)) state_d = S_MATCH_END;
          else                                                      state_d = S_GLOAT;
        end
      end
      S_GLOAT, S_FOUL: if (bus.slowen_i && cnt_inc == GLOAT_C) state_d = S_DARK;
      S_MATCH_END: state_d = S_MATCH_END;
      default: state_d = S_RESET;
    endcase
    // restart overrides everything, including a score update this cycle
    if (bus.restart_i) begin
      state_d     = S_RESET;
      round_win_d = 1'b0;
    end
    if (state_d == S_RESET) scores_d = '0;

    if (state_d != state_q)              cnt_d = '0;
    else if (bus.slowen_i && cnt_q != '1) cnt_d = cnt_inc;
    else                                  cnt_d = cnt_q;
  end

  // Outputs decode the next state so they change on the edge entering it.
  always_comb begin
    leds_on_d = 1'b1;
    clear_d   = 1'b1;
    ctrl_d    = 2'd3;
    case (state_d)
      S_RESET:     begin leds_on_d = 1'b0; clear_d = 1'b1; ctrl_d = 2'd3; end
      S_WAIT:      begin leds_on_d = 1'b1; clear_d = 1'b1; ctrl_d = 2'd3; end
      S_DARK:      begin leds_on_d = 1'b0; clear_d = 1'b0; ctrl_d = 2'd0; end
      S_PLAY:      begin leds_on_d = 1'b1; clear_d = 1'b0; ctrl_d = 2'd1; end
      S_GLOAT:     begin leds_on_d = 1'b1; clear_d = 1'b1; ctrl_d = 2'd2; end
      S_FOUL:      begin leds_on_d = 1'b1; clear_d = 1'b1; ctrl_d = 2'd0; end
      S_MATCH_END: begin leds_on_d = 1'b1; clear_d = 1'b1; ctrl_d = 2'd2; end
      default:     begin leds_on_d = 1'b0; clear_d = 1'b1; ctrl_d = 2'd3; end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      cnt_q        <= '0;
      scores_q     <= '0;
      winner_q     <= '0;
      round_win_q  <= 1'b0;
      leds_on_q    <= 1'b0;
      clear_q      <= 1'b1;
      ctrl_q       <= 2'd3;
      foul_q       <= 1'b0;
      match_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scores_q     <= scores_d;
      winner_q     <= winner_d;
      round_win_q  <= round_win_d;
      leds_on_q    <= leds_on_d;
      clear_q      <= clear_d;
      ctrl_q       <= ctrl_d;
      foul_q       <= (state_d == S_FOUL);
      match_over_q <= (state_d == S_MATCH_END);
    end
  end

  assign bus.leds_on_o     = leds_on_q;
  assign bus.clear_o       = clear_q;
  assign bus.led_control_o = ctrl_q;
  assign bus.round_win_o   = round_win_q;
  assign bus.foul_o        = foul_q;
  assign bus.winner_id_o   = winner_q;
  assign bus.scores_o      = scores_q;
  assign bus.match_over_o  = match_over_q;

endmodule
